// File: rtl/vga_sync.sv
// VGA timing generator: divides clk down to a pixel tick and produces
// registered sync, visible-area and frame-start strobes aligned with (x, y).
module vga_sync #(
    parameter int DIV       = 4,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pixTick,
    output logic       hsync,
    output logic       vsync,
    output logic       readPixel,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       frameStart
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [DW-1:0] div;
    logic [9:0]    hcount;
    logic [9:0]    vcount;
    logic [9:0]    h_next;
    logic [9:0]    v_next;
    logic          tick;

    assign tick = (div == DIV_LAST);
    assign x    = hcount;
    assign y    = vcount;

    // NOTE: defaults first so every path assigns h_next/v_next; no latch is inferred.
    always_comb begin
        h_next = hcount;
        v_next = vcount;
        if (tick) begin
            if (hcount == H_LAST) begin
                h_next = '0;
                v_next = (vcount == V_LAST) ? '0 : vcount + 10'd1;
            end else begin
                h_next = hcount + 10'd1;
            end
        end
    end

    // Strobes decode the next counts so they line up with the x/y registered on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            div        <= '0;
            hcount     <= H_LAST;
            vcount     <= V_LAST;
            pixTick    <= 1'b0;
            frameStart <= 1'b0;
            hsync      <= 1'b1;
            vsync      <= 1'b1;
            readPixel  <= 1'b0;
        end else begin
            div        <= tick ? '0 : div + 1'b1;
            hcount     <= h_next;
            vcount     <= v_next;
            pixTick    <= tick;
            frameStart <= tick && (h_next == '0) && (v_next == '0);
            hsync      <= !((h_next >= HS_START) && (h_next < HS_END));
            vsync      <= !((v_next >= VS_START) && (v_next < VS_END));
            readPixel  <= (h_next < H_VIS) && (v_next < V_VIS);
        end
    end

endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync with shrunk timing: an arithmetic model derives every output
// from the number of clocks since the last reset edge; literal checks pin the model.
module tb_vga_sync;

    localparam int DIV = 3;
    localparam int HV = 8, HF = 2, HS = 3, HB = 2;
    localparam int VV = 6, VF = 2, VS = 2, VB = 3;
    localparam int HT = HV + HF + HS + HB;   // 15
    localparam int VT = VV + VF + VS + VB;   // 13
    localparam int FRAME = HT * VT * DIV;    // 585 clks

    typedef struct packed {
        logic       pix_tick;
        logic       hsync;
        logic       vsync;
        logic       read_pixel;
        logic       frame_start;
        logic [9:0] x;
        logic [9:0] y;
    } outs_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pixTick, hsync, vsync, readPixel, frameStart;
    logic [9:0] x, y;

    int n_cmp = 0;
    int n_bad = 0;
    int n_since_rst = -1;

    vga_sync #(
        .DIV(DIV), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .clk(clk), .rst(rst), .pixTick(pixTick), .hsync(hsync), .vsync(vsync),
        .readPixel(readPixel), .x(x), .y(y), .frameStart(frameStart)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    // Outputs as a function of clocks elapsed since the last reset edge.
    function automatic outs_t model(input int n);
        outs_t o;
        int p, l, xi, yi;
        p = n / DIV;
        if (p == 0) begin
            o = '{pix_tick: 1'b0, hsync: 1'b1, vsync: 1'b1, read_pixel: 1'b0,
                  frame_start: 1'b0, x: 10'(HT - 1), y: 10'(VT - 1)};
        end else begin
            l  = (p - 1) % (HT * VT);
            xi = l % HT;
            yi = l / HT;
            o.pix_tick    = (n % DIV == 0);
            o.frame_start = (n % DIV == 0) && (l == 0);
            o.hsync       = !(xi >= HV + HF && xi < HV + HF + HS);
            o.vsync       = !(yi >= VV + VF && yi < VV + VF + VS);
            o.read_pixel  = (xi < HV) && (yi < VV);
            o.x           = 10'(xi);
            o.y           = 10'(yi);
        end
        return o;
    endfunction

    always @(posedge clk) begin
        if (rst) n_since_rst <= 0;
        else if (n_since_rst >= 0) n_since_rst <= n_since_rst + 1;
    end

    logic [9:0] prev_x, prev_y;

    always @(negedge clk) begin
        outs_t got;
        if (n_since_rst >= 0) begin
            got = '{pixTick, hsync, vsync, readPixel, frameStart, x, y};
            check($sformatf("model n=%0d", n_since_rst), 32'(got), 32'(model(n_since_rst)));
            if (n_since_rst > 0 && (x != prev_x || y != prev_y))
                check($sformatf("xy_move_needs_tick n=%0d", n_since_rst), 32'(pixTick), 32'd1);
        end
        prev_x = x;
        prev_y = y;
    end

    task automatic step(input int k);
        repeat (k) @(negedge clk);
    endtask

    initial begin
        int pt_cnt, hs_low, vs_low, fs_cnt, fs_first, fs_second;
        bit found;

        rst = 1'b1;
        step(3);
        rst = 1'b0;
        step(DIV - 1);
        check("pre_tick_x", 32'(x), 32'd14);
        check("pre_tick_frameStart", 32'(frameStart), 32'd0);
        step(1);
        check("release_xy_fs_rp", {20'd0, x, y, frameStart, readPixel}, {20'd0, 10'd0, 10'd0, 1'b1, 1'b1});
        step(1);
        check("frameStart_one_clk", 32'(frameStart), 32'd0);

        // Two frames from just after the first frame start; the window ends on the third pulse.
        pt_cnt = 0; hs_low = 0; vs_low = 0; fs_cnt = 0; fs_first = 0; fs_second = 0;
        for (int i = 2; i <= 2 * FRAME + 1; i++) begin
            if (pixTick) pt_cnt++;
            if (!hsync) hs_low++;
            if (!vsync) vs_low++;
            if (frameStart) begin
                fs_cnt++;
                if (fs_cnt == 1) fs_first = i - 1;
                if (fs_cnt == 2) fs_second = i - 1;
            end
            if (i < 2 * FRAME + 1) step(1);
        end
        check("frame_period_1", 32'(fs_first), 32'd585);
        check("frame_period_2", 32'(fs_second - fs_first), 32'd585);
        check("pixTick_per_2frames", 32'(pt_cnt), 32'd390);
        check("hsync_low_clks", 32'(hs_low), 32'd234);
        check("vsync_low_clks", 32'(vs_low), 32'd180);

        // Reset while both syncs are active.
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            if (x == 10'd11 && y == 10'd8) found = 1'b1;
            else step(1);
        end
        check("reach_mid_sync", 32'(found), 32'd1);
        check("syncs_low_before_rst", {30'd0, hsync, vsync}, 32'd0);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("mid_sync_rst", {7'd0, x, y, hsync, vsync, readPixel, pixTick, frameStart},
              {7'd0, 10'd14, 10'd12, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        step(DIV);
        check("rerelease_xy", {12'd0, x, y}, 32'd0);

        // Randomised reset pulses; the model follows every cycle.
        for (int r = 0; r < 20; r++) begin
            step($urandom_range(1, 400));
            rst = 1'b1;
            step($urandom_range(1, 3));
            rst = 1'b0;
        end
        step(2 * FRAME);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
